// File: rtl/exp_pkg.sv
// exp_pkg: shared types, sizes, Taylor coefficients and input ROM for exp_wrapped
package exp_pkg;
  localparam int N = 16;
  localparam int W = 18;
  localparam int TERMS = 7;
  localparam int PW = 2 * W;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CALC  = 3'd2,
    STORE = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } state_t;
  // 1/k! in Q.16 for k = 1..7
  function automatic logic [W-1:0] coef(input logic [2:0] k);
    case (k)
      3'd1:    return W'(65536);
      3'd2:    return W'(32768);
      3'd3:    return W'(10923);
      3'd4:    return W'(2731);
      3'd5:    return W'(546);
      3'd6:    return W'(91);
      3'd7:    return W'(13);
      default: return '0;
    endcase
  endfunction
  // input table entry i is x = i/16 in Q2.16
  function automatic logic [W-1:0] rom(input logic [3:0] i);
    return {2'b00, i, 12'h000};
  endfunction
endpackage

// File: rtl/exp_core.sv
// exp_core: Taylor-series datapath for e^x
//   clk, reset (async, active-low), load: init p/acc/k, step: one term,
//   x: Q2.16 operand, acc: running sum, last: current step is term TERMS
module exp_core
  import exp_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] x,
  output logic [W-1:0] acc,
  output logic         last
);
  logic [W-1:0] p, p_nxt, term;
  logic [2:0]   k;
  assign p_nxt = W'((PW'(p) * PW'(x)) >> 16);
  assign term  = W'((PW'(p_nxt) * PW'(coef(k))) >> 16);
  assign last  = k == 3'(TERMS);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      p   <= '0;
      acc <= '0;
      k   <= '0;
    end else if (load) begin
      p   <= W'(65536);
      acc <= W'(65536);
      k   <= 3'd1;
    end else if (step) begin
      p   <= p_nxt;
      acc <= acc + term;
      k   <= k + 3'd1;
    end
endmodule

// File: rtl/exp_wrapped.sv
// exp_wrapped: e^x over a 16-entry ROM with stepped readout of input/result pairs
//   clk, reset (async, active-low), Start: run request, ReadSwitch: step readout,
//   Done: results valid, Cout: count at N-1, count: element index,
//   data: ROM[count], exp_result: result[count], ps: FSM state
module exp_wrapped
  import exp_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  output logic         Done,
  input  logic         Start,
  input  logic         ReadSwitch,
  output logic         Cout,
  output logic [7:0]   count,
  output logic [W-1:0] data,
  output logic [W-1:0] exp_result,
  output logic [2:0]   ps
);
  state_t       st, st_nxt;
  logic [7:0]   cnt_nxt;
  logic         rs_s, rs_d, rise, last;
  logic [W-1:0] acc;
  logic [W-1:0] bank [N];
  assign ps         = st;
  assign Done       = st == DONE;
  assign Cout       = count == 8'(N - 1);
  assign data       = rom(count[3:0]);
  assign exp_result = bank[count[3:0]];
  // rs_s samples the switch, rs_d delays it: one step per rising edge
  assign rise       = rs_s & ~rs_d;
  exp_core u_core (
    .clk  (clk),
    .reset(reset),
    .load (st == LOAD),
    .step (st == CALC),
    .x    (data),
    .acc  (acc),
    .last (last)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st    <= IDLE;
      count <= '0;
      rs_s  <= 1'b0;
      rs_d  <= 1'b0;
    end else begin
      st    <= st_nxt;
      count <= cnt_nxt;
      rs_s  <= ReadSwitch;
      rs_d  <= rs_s;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < N; i++) bank[i] <= '0;
    end else if (st == STORE) begin
      bank[count[3:0]] <= acc;
    end
  always_comb begin
    st_nxt  = st;
    cnt_nxt = count;
    case (st)
      IDLE: begin
        st_nxt  = Start ? LOAD : IDLE;
        cnt_nxt = Start ? '0 : count;
      end
      LOAD:  st_nxt = CALC;
      CALC:  st_nxt = last ? STORE : CALC;
      STORE: st_nxt = NEXT;
      NEXT: begin
        st_nxt  = Cout ? DONE : LOAD;
        cnt_nxt = Cout ? '0 : count + 8'd1;
      end
      DONE: begin
        st_nxt  = Start ? LOAD : DONE;
        cnt_nxt = Start ? '0 : rise ? (Cout ? '0 : count + 8'd1) : count;
      end
      default: st_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_exp_wrapped.sv
// tb_exp_wrapped: scoreboard bench for exp_wrapped against an arithmetic Taylor model
module tb_exp_wrapped;
  logic        clk = 1'b0, reset = 1'b0, Start = 1'b0, ReadSwitch = 1'b0;
  logic        Done, Cout;
  logic [7:0]  count;
  logic [17:0] data, exp_result;
  logic [2:0]  ps;
  exp_wrapped dut (
    .clk       (clk),
    .reset     (reset),
    .Done      (Done),
    .Start     (Start),
    .ReadSwitch(ReadSwitch),
    .Cout      (Cout),
    .count     (count),
    .data      (data),
    .exp_result(exp_result),
    .ps        (ps)
  );
  always #5 clk = ~clk;
  typedef struct {
    int idx;
    int dat;
    int res;
    bit cout;
  } exp_t;
  exp_t       q[$];
  exp_t       m_e;
  int         model[16];
  int         ideal[16];
  int         checks = 0, errors = 0, cur = 0, diff;
  logic       done_p = 1'b0;
  logic [7:0] cnt_p = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, req);
    end
  endtask
  // monitor: every newly presented readout pair must match the next expectation
  always @(negedge clk) begin
    if (Done && (!done_p || count != cnt_p)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_step got count %0d want no step", count);
      end else begin
        m_e = q.pop_front();
        chk("rd_count", 32'(count), m_e.idx);
        chk("rd_data", 32'(data), m_e.dat);
        chk("rd_result", 32'(exp_result), m_e.res);
        chk("rd_cout", 32'(Cout), 32'(m_e.cout));
        diff = int'(exp_result) - ideal[m_e.idx];
        checks++;
        if (diff < -8 || diff > 8) begin
          errors++;
          $display("FAIL rd_accuracy idx %0d got %0d want %0d+-8", m_e.idx, exp_result, ideal[m_e.idx]);
        end
      end
    end
    done_p = Done;
    cnt_p  = count;
  end
  task automatic run(input bit hold, input bit tog);
    int e_done;
    e_done = 0;
    q.push_back('{0, 0, model[0], 1'b0});
    @(posedge clk); #1 Start = 1'b1;
    @(posedge clk); #1;
    chk("start_ps", 32'(ps), 1);
    chk("start_count", 32'(count), 0);
    chk("start_done", 32'(Done), 0);
    Start = hold;
    for (int e = 2; e <= 200 && e_done == 0; e++) begin
      @(posedge clk); #1;
      if (Done) e_done = e;
      else begin
        Start      = hold && e < 30;
        ReadSwitch = (tog && e < 140) ? 1'($urandom) : 1'b0;
      end
    end
    Start      = 1'b0;
    ReadSwitch = 1'b0;
    chk("done_latency", e_done, 161);
    chk("done_ps", 32'(ps), 5);
    chk("done_count", 32'(count), 0);
    cur = 0;
  endtask
  task automatic readout(input int n);
    for (int i = 0; i < n; i++) begin
      cur = (cur + 1) % 16;
      q.push_back('{cur, cur << 12, model[cur], cur == 15});
      @(posedge clk); #1 ReadSwitch = 1'b1;
      @(posedge clk); #1 ReadSwitch = 1'b0;
      repeat (2) @(posedge clk);
    end
    repeat (3) @(posedge clk);
    chk("readout_drained", q.size(), 0);
  endtask
  task automatic held();
    cur = (cur + 1) % 16;
    q.push_back('{cur, cur << 12, model[cur], cur == 15});
    @(posedge clk); #1 ReadSwitch = 1'b1;
    repeat (10) @(posedge clk);
    #1 ReadSwitch = 1'b0;
    repeat (4) @(posedge clk);
    chk("held_drained", q.size(), 0);
  endtask
  task automatic reset_vals(input string tag);
    chk({tag, "_ps"}, 32'(ps), 0);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_done"}, 32'(Done), 0);
    chk({tag, "_cout"}, 32'(Cout), 0);
    chk({tag, "_result"}, 32'(exp_result), 0);
    chk({tag, "_data"}, 32'(data), 0);
  endtask
  initial begin
    longint c[7] = '{65536, 32768, 10923, 2731, 546, 91, 13};
    longint x, p, acc;
    for (int i = 0; i < 16; i++) begin
      x   = longint'(i) * 4096;
      p   = 65536;
      acc = 65536;
      for (int k = 0; k < 7; k++) begin
        p   = (p * x) >> 16;
        acc = acc + ((p * c[k]) >> 16);
      end
      model[i] = int'(acc & 64'h3ffff);
      ideal[i] = $rtoi($exp(real'(i) / 16.0) * 65536.0 + 0.5);
    end
    repeat (3) @(posedge clk);
    #1 reset_vals("rst_hold");
    reset = 1'b1;
    @(posedge clk); #1 reset_vals("rst_release");
    run(1'b0, 1'b0);
    readout(16);
    held();
    run(1'b1, 1'b1);
    readout(16);
    @(posedge clk); #1 Start = 1'b1;
    @(posedge clk); #1 Start = 1'b0;
    repeat (53) @(posedge clk);
    #1 chk("mid_ps_calc", 32'(ps), 2);
    chk("mid_count", 32'(count), 5);
    reset = 1'b0;
    #1 reset_vals("mid_rst");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    run(1'b0, 1'b0);
    readout(16);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
